// File: rtl/disp_bus_sched.sv
// Display nibble-bus scheduler: grants source B a fixed dwell window, then forces
// a minimum source-A gap so the background credit value is never starved.
module disp_bus_sched #(
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 2,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_b,
    input  logic       abort_b,
    output logic       mux_sel,
    output logic       ack_b,
    output logic       done_b,
    output logic       busy,
    output logic [7:0] serve_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_GAP   = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             enter_grant_s;
    logic             enter_gap_s;
    logic             mux_sel_nxt_s;
    logic             busy_nxt_s;
    logic [7:0]       serve_cnt_nxt_s;

    // State, dwell counter and all outputs registered on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            mux_sel   <= 1'b0;
            ack_b     <= 1'b0;
            done_b    <= 1'b0;
            busy      <= 1'b0;
            serve_cnt <= 8'd0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            mux_sel   <= mux_sel_nxt_s;
            ack_b     <= enter_grant_s;
            done_b    <= enter_gap_s;
            busy      <= busy_nxt_s;
            serve_cnt <= serve_cnt_nxt_s;
        end
    end

    // Next-state and counter reload/decrement
    always_comb begin
        state_nxt_s   = ST_IDLE;
        cnt_nxt_s     = CNT_ZERO;
        enter_grant_s = 1'b0;
        enter_gap_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_b) begin
                    state_nxt_s   = ST_GRANT;
                    cnt_nxt_s     = HOLD_LOAD;
                    enter_grant_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            ST_GRANT: begin
                // Abort and natural expiry collapse into one exit, hence one done_b
                if ((cnt_r == CNT_ZERO) || abort_b) begin
                    state_nxt_s = ST_GAP;
                    cnt_nxt_s   = GAP_LOAD;
                    enter_gap_s = 1'b1;
                end else begin
                    state_nxt_s = ST_GRANT;
                    cnt_nxt_s   = cnt_r - CNT_ONE;
                end
            end
            ST_GAP: begin
                if (cnt_r != CNT_ZERO) begin
                    state_nxt_s = ST_GAP;
                    cnt_nxt_s   = cnt_r - CNT_ONE;
                end else if (req_b) begin
                    state_nxt_s   = ST_GRANT;
                    cnt_nxt_s     = HOLD_LOAD;
                    enter_grant_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state
    always_comb begin
        mux_sel_nxt_s   = (state_nxt_s == ST_GRANT);
        busy_nxt_s      = (state_nxt_s != ST_IDLE);
        serve_cnt_nxt_s = serve_cnt;
        if (enter_grant_s && (serve_cnt != 8'hFF)) begin
            serve_cnt_nxt_s = serve_cnt + 8'd1;
        end else begin
            serve_cnt_nxt_s = serve_cnt;
        end
    end

endmodule

// File: tb/tb_disp_bus_sched.sv
// Bench for disp_bus_sched: table of directed vectors, hand sequences for reset
// and sustained request, and random traffic against a timestamp-based model.
module tb_disp_bus_sched;

    localparam int HOLD = 8;
    localparam int GAP  = 2;
    localparam int NROW = 55;

    logic       clk;
    logic       rst_n;
    logic       req_b;
    logic       abort_b;
    logic       mux_sel;
    logic       ack_b;
    logic       done_b;
    logic       busy;
    logic [7:0] serve_cnt;

    int checks = 0;
    int errors = 0;
    int e      = 0;

    // Model: grant covers cycles [gs, ge), gap covers [ge, gpe)
    int gs     = -100;
    int ge     = -100;
    int gpe    = -100;
    int served = 0;

    typedef struct {
        logic       req;
        logic       abort;
        logic       sel;
        logic       ack;
        logic       done;
        logic       busy;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl [1:NROW];

    disp_bus_sched #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_b     (req_b),
        .abort_b   (abort_b),
        .mux_sel   (mux_sel),
        .ack_b     (ack_b),
        .done_b    (done_b),
        .busy      (busy),
        .serve_cnt (serve_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit in_grant(input int c);
        return (c >= gs) && (c < ge);
    endfunction

    function automatic bit in_gap(input int c);
        return (c >= ge) && (c < gpe);
    endfunction

    task automatic model_reset();
        gs = -100; ge = -100; gpe = -100; served = 0;
    endtask

    task automatic model_start();
        gs  = e;
        ge  = e + HOLD;
        gpe = e + HOLD + GAP;
        if (served < 255) served++;
    endtask

    task automatic model_step(input logic r, input logic a);
        int c;
        c = e - 1;
        if (in_grant(c)) begin
            if (a && (e < ge)) begin
                ge  = e;
                gpe = e + GAP;
            end
        end else if (in_gap(c)) begin
            if ((e == gpe) && r) model_start();
        end else begin
            if (r) model_start();
        end
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", nm, e, act, exp);
        end
    endtask

    task automatic chk_model();
        chk("mux_sel", {7'd0, mux_sel}, {7'd0, in_grant(e)});
        chk("ack_b",   {7'd0, ack_b},   {7'd0, (gs == e)});
        chk("done_b",  {7'd0, done_b},  {7'd0, (ge == e)});
        chk("busy",    {7'd0, busy},    {7'd0, (in_grant(e) || in_gap(e))});
        chk("serve_cnt", serve_cnt, 8'(served));
    endtask

    task automatic drive_edge(input logic r, input logic a);
        req_b   = r;
        abort_b = a;
        @(posedge clk);
        #1;
        e++;
        model_step(r, a);
    endtask

    initial begin
        int ack_seen;
        int base;
        logic r;
        logic a;

        for (int i = 1; i <= NROW; i++) begin
            tbl[i].req   = (i == 5) || (i == 20) || (i == 40);
            tbl[i].abort = (i == 28) || (i == 43) || (i == 50);
            tbl[i].sel   = (i >= 5 && i <= 12) || (i >= 20 && i <= 27) || (i >= 40 && i <= 42);
            tbl[i].ack   = (i == 5) || (i == 20) || (i == 40);
            tbl[i].done  = (i == 13) || (i == 28) || (i == 43);
            tbl[i].busy  = (i >= 5 && i <= 14) || (i >= 20 && i <= 29) || (i >= 40 && i <= 44);
            tbl[i].cnt   = (i < 5) ? 8'd0 : (i < 20) ? 8'd1 : (i < 40) ? 8'd2 : 8'd3;
        end

        rst_n   = 1'b0;
        req_b   = 1'b0;
        abort_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mux_sel", {7'd0, mux_sel}, 8'd0);
        chk("rst_busy",    {7'd0, busy},    8'd0);
        chk("rst_ack",     {7'd0, ack_b},   8'd0);
        chk("rst_done",    {7'd0, done_b},  8'd0);
        chk("rst_serve",   serve_cnt,       8'd0);
        rst_n = 1'b1;
        e = 0;
        model_reset();

        // Directed table: single pulse, abort on last cycle, abort on 3rd cycle, abort in IDLE
        for (int i = 1; i <= NROW; i++) begin
            drive_edge(tbl[i].req, tbl[i].abort);
            chk("tbl_sel",   {7'd0, mux_sel}, {7'd0, tbl[i].sel});
            chk("tbl_ack",   {7'd0, ack_b},   {7'd0, tbl[i].ack});
            chk("tbl_done",  {7'd0, done_b},  {7'd0, tbl[i].done});
            chk("tbl_busy",  {7'd0, busy},    {7'd0, tbl[i].busy});
            chk("tbl_serve", serve_cnt,       tbl[i].cnt);
        end

        // Request held for 40 cycles: acks every HOLD+GAP cycles
        base = served;
        ack_seen = 0;
        for (int i = 0; i < 40; i++) begin
            drive_edge(1'b1, 1'b0);
            chk("hold_sel", {7'd0, mux_sel}, {7'd0, ((i % (HOLD + GAP)) < HOLD)});
            chk("hold_ack", {7'd0, ack_b},   {7'd0, ((i % (HOLD + GAP)) == 0)});
            if (ack_b) ack_seen++;
        end
        chk("hold_ack_count", 8'(ack_seen), 8'd4);
        chk("hold_serve", serve_cnt, 8'(base + 4));
        repeat (12) begin
            drive_edge(1'b0, 1'b0);
            chk_model();
        end

        // Async reset mid-grant
        drive_edge(1'b1, 1'b0);
        chk_model();
        repeat (3) begin
            drive_edge(1'b0, 1'b0);
            chk_model();
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sel",   {7'd0, mux_sel}, 8'd0);
        chk("arst_busy",  {7'd0, busy},    8'd0);
        chk("arst_done",  {7'd0, done_b},  8'd0);
        chk("arst_serve", serve_cnt,       8'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        repeat (6) begin
            drive_edge(1'b0, 1'b0);
            chk_model();
            chk("post_rst_done", {7'd0, done_b}, 8'd0);
        end

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            r = ($urandom_range(0, 99) < ((i / 300) % 2 == 0 ? 30 : 80));
            a = ($urandom_range(0, 99) < 15);
            drive_edge(r, a);
            chk_model();
        end

        // 260+ back-to-back grants: saturation with unchanged pattern
        for (int i = 0; i < 2620; i++) begin
            drive_edge(1'b1, 1'b0);
            chk_model();
        end
        chk("sat_serve", serve_cnt, 8'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
